// File: rtl/tanh_sequencer.sv
// tanh_sequencer: front-end controller for the tanh interpolation datapath.
// Folds a signed operand to magnitude, sequences start_tanh/start_interpolation
// with fixed latencies, captures the datapath result, restores the sign and
// returns it over a valid/ready handshake. One operation in flight at a time.
module tanh_sequencer #(
  parameter int unsigned TANH_LAT = 2,
  parameter int unsigned RES_LAT  = 1,
  parameter logic [16:0] SAT_MAG  = 17'h1FFFF,
  parameter logic [15:0] SAT_VAL  = 16'hFFFF
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [17:0] x_in,
  output logic [16:0] a_mod,
  output logic        start_tanh,
  output logic        start_interpolation,
  input  logic [15:0] tanh_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [16:0] y_out,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    WAIT_T = 3'd2,
    INTERP = 3'd3,
    WAIT_R = 3'd4,
    OUT    = 3'd5
  } state_t;

  localparam logic [3:0] TANH_CNT_INIT = 4'(TANH_LAT - 1);
  localparam logic [3:0] RES_CNT_INIT  = 4'(RES_LAT - 1);
  localparam bit         TANH_MULTI    = (TANH_LAT > 1);

  // Magnitude of a signed operand; the most negative value has no positive
  // counterpart in 17 bits and is pinned to full scale so it saturates.
  function automatic logic [16:0] fold_mag(input logic [17:0] x);
    logic [17:0] neg;
    neg = 18'd0 - x;
    if (x == 18'h20000) begin
      return 17'h1FFFF;
    end else if (x[17]) begin
      return neg[16:0];
    end else begin
      return x[16:0];
    end
  endfunction

  // Re-apply the operand sign to a 16-bit magnitude; zero stays zero.
  function automatic logic [16:0] apply_sign(input logic sign, input logic [15:0] mag);
    logic [16:0] ext;
    ext = {1'b0, mag};
    if (sign) begin
      return 17'd0 - ext;
    end else begin
      return ext;
    end
  endfunction

  state_t      state_r, state_s;
  logic [3:0]  cnt_r, cnt_s;
  logic        sign_r, sign_s;
  logic [16:0] a_mod_r, a_mod_s;
  logic [15:0] res_r, res_s;
  logic [16:0] mag_fold_s;
  logic [16:0] y_s;
  logic        in_ready_r, start_tanh_r, start_interp_r, out_valid_r, busy_r;
  logic [16:0] y_out_r;

  assign in_ready            = in_ready_r;
  assign a_mod               = a_mod_r;
  assign start_tanh          = start_tanh_r;
  assign start_interpolation = start_interp_r;
  assign out_valid           = out_valid_r;
  assign y_out               = y_out_r;
  assign busy                = busy_r;

  // Next-state, counter and operand-capture logic.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    sign_s     = sign_r;
    a_mod_s    = a_mod_r;
    res_s      = res_r;
    mag_fold_s = fold_mag(x_in);
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          sign_s  = x_in[17];
          a_mod_s = mag_fold_s;
          if (mag_fold_s >= SAT_MAG) begin
            res_s   = SAT_VAL;
            state_s = OUT;
          end else begin
            state_s = LAUNCH;
          end
        end else begin
          state_s = IDLE;
        end
      end
      LAUNCH: begin
        cnt_s = TANH_CNT_INIT;
        if (TANH_MULTI) begin
          state_s = WAIT_T;
        end else begin
          state_s = INTERP;
        end
      end
      WAIT_T: begin
        if (cnt_r <= 4'd1) begin
          cnt_s   = 4'd0;
          state_s = INTERP;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      INTERP: begin
        cnt_s   = RES_CNT_INIT;
        state_s = WAIT_R;
      end
      WAIT_R: begin
        if (cnt_r == 4'd0) begin
          res_s   = tanh_result;
          state_s = OUT;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      OUT: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = OUT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    y_s = apply_sign(sign_s, res_s);
  end

  // State register plus outputs registered from the next state.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r        <= IDLE;
      cnt_r          <= 4'd0;
      sign_r         <= 1'b0;
      a_mod_r        <= 17'd0;
      res_r          <= 16'd0;
      in_ready_r     <= 1'b1;
      start_tanh_r   <= 1'b0;
      start_interp_r <= 1'b0;
      out_valid_r    <= 1'b0;
      y_out_r        <= 17'd0;
      busy_r         <= 1'b0;
    end else begin
      state_r        <= state_s;
      cnt_r          <= cnt_s;
      sign_r         <= sign_s;
      a_mod_r        <= a_mod_s;
      res_r          <= res_s;
      in_ready_r     <= (state_s == IDLE);
      start_tanh_r   <= (state_s == LAUNCH);
      start_interp_r <= (state_s == INTERP);
      out_valid_r    <= (state_s == OUT);
      busy_r         <= (state_s != IDLE);
      if (state_s == OUT) begin
        y_out_r <= y_s;
      end else begin
        y_out_r <= y_out_r;
      end
    end
  end

endmodule

// File: tb/tb_tanh_sequencer.sv
// Scoreboard bench for tanh_sequencer: the driver pushes expected responses at
// acceptance; a negedge monitor models the datapath and checks strobes/results.
module tb_tanh_sequencer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready;
  logic [17:0] x_in;
  logic [16:0] a_mod;
  logic        start_tanh, start_interpolation;
  logic [15:0] tanh_result = 16'hBEEF;
  logic        out_valid, out_ready;
  logic [16:0] y_out;
  logic        busy;

  logic        in_valid2, in_ready2, st2, si2, out_valid2, busy2;
  logic [17:0] x_in2;
  logic [16:0] a_mod2, y_out2;
  logic [15:0] tres2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [16:0] y;
    logic [16:0] amod;
    logic [15:0] tres;
    int          st;
    int          si;
    int          ov;
    bit          sat;
  } exp_t;
  exp_t q[$];

  tanh_sequencer dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .a_mod(a_mod), .start_tanh(start_tanh),
    .start_interpolation(start_interpolation), .tanh_result(tanh_result),
    .out_valid(out_valid), .out_ready(out_ready), .y_out(y_out), .busy(busy)
  );

  tanh_sequencer #(.TANH_LAT(1), .RES_LAT(3)) dut2 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .x_in(x_in2), .a_mod(a_mod2), .start_tanh(st2),
    .start_interpolation(si2), .tanh_result(tres2),
    .out_valid(out_valid2), .out_ready(1'b1), .y_out(y_out2), .busy(busy2)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Scoreboard monitor and datapath model
  int          n_st = 0;
  int          n_si = 0;
  int          sample_cyc = -1;
  logic [15:0] model_val = 16'h0000;
  logic        prev_ov = 1'b0;
  exp_t        h;

  always @(negedge clock) begin
    if (q.size() > 0) h = q[0];
    if (start_tanh) begin
      n_st++;
      if (q.size() == 0) chk("unexpected_start_tanh", 32'd1, 32'd0);
      else begin
        chk("start_tanh_cycle", cyc, h.st);
        chk("a_mod_at_start", a_mod, h.amod);
      end
    end
    if (start_interpolation) begin
      n_si++;
      if (start_tanh) chk("strobe_overlap", 32'd1, 32'd0);
      if (q.size() == 0) chk("unexpected_start_interp", 32'd1, 32'd0);
      else begin
        chk("start_interp_cycle", cyc, h.si);
        sample_cyc = cyc + 1;
        model_val  = h.tres;
      end
    end
    tanh_result = (cyc == sample_cyc) ? model_val : 16'hBEEF;
    if (out_valid) begin
      if (q.size() == 0) chk("unexpected_out_valid", 32'd1, 32'd0);
      else begin
        if (!prev_ov) begin
          chk("out_valid_cycle", cyc, h.ov);
          chk("a_mod_held", a_mod, h.amod);
        end
        chk("y_out", y_out, h.y);
        chk("in_ready_in_out", in_ready, 32'd0);
        chk("busy_in_out", busy, 32'd1);
        if (out_ready) begin
          chk("n_start_tanh", n_st, h.sat ? 0 : 1);
          chk("n_start_interp", n_si, h.sat ? 0 : 1);
          void'(q.pop_front());
          n_st = 0;
          n_si = 0;
        end
      end
    end
    prev_ov = out_valid;
    if (!reset_n) begin
      q.delete();
      n_st = 0;
      n_si = 0;
      sample_cyc = -1;
      prev_ov = 1'b0;
    end
  end

  task automatic send(input logic [17:0] x, input logic [15:0] tres, input logic [16:0] amod,
                      input logic [16:0] y, input bit sat, output int acc);
    int n;
    exp_t e;
    n = 0;
    in_valid = 1'b1;
    x_in = x;
    while (!in_ready && n < 60) begin
      @(posedge clock); #1;
      n++;
    end
    chk("accept_timeout", in_ready, 32'd1);
    acc = cyc;
    e.y = y; e.amod = amod; e.tres = tres; e.sat = sat;
    e.st = sat ? -1 : acc + 1;
    e.si = sat ? -1 : acc + 3;
    e.ov = sat ? acc + 1 : acc + 5;
    if (in_ready) q.push_back(e);
    @(posedge clock); #1;
    in_valid = 1'b0;
    x_in = 18'h2AAAA;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    chk("drain", q.size(), 32'd0);
  endtask

  task automatic chk_reset();
    chk("rst_in_ready", in_ready, 32'd1);
    chk("rst_a_mod", a_mod, 32'd0);
    chk("rst_start_tanh", start_tanh, 32'd0);
    chk("rst_start_interp", start_interpolation, 32'd0);
    chk("rst_out_valid", out_valid, 32'd0);
    chk("rst_y_out", y_out, 32'd0);
    chk("rst_busy", busy, 32'd0);
  endtask

  typedef struct {
    logic [17:0] x;
    logic [15:0] tres;
    logic [16:0] amod;
    logic [16:0] y;
    bit          sat;
  } vec_t;

  vec_t vecs[8] = '{
    '{18'h00400, 16'h3A21, 17'h00400, 17'h03A21, 1'b0},
    '{18'h3FC00, 16'h3A21, 17'h00400, 17'h1C5DF, 1'b0},
    '{18'h3FFFF, 16'h0100, 17'h00001, 17'h1FF00, 1'b0},
    '{18'h20000, 16'h0000, 17'h1FFFF, 17'h10001, 1'b1},
    '{18'h00000, 16'h0000, 17'h00000, 17'h00000, 1'b0},
    '{18'h1FFFF, 16'h0000, 17'h1FFFF, 17'h0FFFF, 1'b1},
    '{18'h3FFFE, 16'h0000, 17'h00002, 17'h00000, 1'b0},
    '{18'h1FFFE, 16'h7FFF, 17'h1FFFE, 17'h07FFF, 1'b0}
  };

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc[8];
    int a1, a2, hs, n;
    reset_n = 1'b0; in_valid = 1'b0; x_in = 18'd0; out_ready = 1'b1;
    in_valid2 = 1'b0; x_in2 = 18'd0; tres2 = 16'hBEEF;
    repeat (3) @(posedge clock);
    #1;
    chk_reset();
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Directed vectors, back to back with out_ready high
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].x, vecs[i].tres, vecs[i].amod, vecs[i].y, vecs[i].sat, acc[i]);
    end
    drain();
    chk("accept_spacing_normal", acc[1] - acc[0], 32'd6);
    chk("accept_spacing_sat", acc[4] - acc[3], 32'd2);

    // Output back-pressure: 4 stalled cycles, second operand waits
    out_ready = 1'b0;
    hs = -100;
    fork
      begin
        send(18'h00400, 16'h1234, 17'h00400, 17'h01234, 1'b0, a1);
        send(18'h00010, 16'h0042, 17'h00010, 17'h00042, 1'b0, a2);
      end
      begin
        n = 0;
        while (!out_valid && n < 60) begin
          @(posedge clock); #1;
          n++;
        end
        chk("stall_out_valid_seen", out_valid, 32'd1);
        repeat (4) begin
          @(posedge clock); #1;
        end
        out_ready = 1'b1;
        hs = cyc;
      end
    join
    drain();
    chk("accept_after_out_hs", a2, hs + 1);

    // Reset in the start_interpolation cycle abandons the operation
    send(18'h00400, 16'h3A21, 17'h00400, 17'h03A21, 1'b0, a1);
    n = 0;
    while (!start_interpolation && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    chk("reset_test_si_seen", start_interpolation, 32'd1);
    reset_n = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    chk_reset();
    for (int k = 0; k < 6; k++) begin
      @(posedge clock); #1;
      chk("no_out_after_reset", out_valid, 32'd0);
    end
    send(18'h3FC00, 16'h3A21, 17'h00400, 17'h1C5DF, 1'b0, a1);
    drain();

    // TANH_LAT=1, RES_LAT=3 instance
    in_valid2 = 1'b1;
    x_in2 = 18'h3FC00;
    chk("lat2_in_ready", in_ready2, 32'd1);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clock); #1;
      in_valid2 = 1'b0;
      x_in2 = 18'h15555;
      tres2 = (k == 5) ? 16'h0ABC : 16'hBEEF;
      chk("lat2_start_tanh", st2, (k == 1) ? 32'd1 : 32'd0);
      chk("lat2_start_interp", si2, (k == 2) ? 32'd1 : 32'd0);
      chk("lat2_out_valid", out_valid2, (k == 6) ? 32'd1 : 32'd0);
      if (k == 6) begin
        chk("lat2_y_out", y_out2, 32'h1F544);
        chk("lat2_a_mod", a_mod2, 32'h00400);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tanh_sequencer.md
Name: tanh_sequencer

Overview:
- Front-end controller and initiator for the tanh interpolation datapath.
- Accepts signed operands over a valid/ready handshake and folds each one to magnitude, since tanh is odd.
- Drives the datapath's a_mod, start_tanh and start_interpolation in the required order and timing, then captures tanh_result.
- Restores the sign, saturates out-of-range operands, and returns results over a second valid/ready handshake. One operation in flight at a time.

Parameters:
- TANH_LAT, 2, cycles from the start_tanh pulse to the start_interpolation pulse (covers the LUT read and X-difference/multiply stages); legal range 1..15.
- RES_LAT, 1, cycles from the start_interpolation pulse to tanh_result being valid; legal range 1..15.
- SAT_MAG, 17'h1FFFF, magnitude at or above which the datapath is bypassed.
- SAT_VAL, 16'hFFFF, result magnitude returned when the datapath is bypassed.

Ports:
- clock  input  1  system clock; all logic on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operand valid.
- in_ready  output  1  sequencer can accept an operand.
- x_in  input  18  signed two's-complement operand.
- a_mod  output  17  magnitude to the datapath.
- start_tanh  output  1  one-cycle pulse that launches address/X generation.
- start_interpolation  output  1  one-cycle pulse that launches result accumulation.
- tanh_result  input  16  unsigned magnitude result from the datapath.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- y_out  output  17  signed two's-complement result.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (reset_n low at a clock edge): state goes to IDLE. Reset values: in_ready=1, a_mod=0, start_tanh=0, start_interpolation=0, out_valid=0, y_out=0, busy=0, delay counter=0. Reset mid-operation abandons the operation; no result is ever emitted for it.
- States: IDLE, LAUNCH, WAIT_T, INTERP, WAIT_R, OUT.
- IDLE: in_ready=1. On in_valid & in_ready, register the sign and the magnitude.
  - mag = x_in[17] ? -x_in : x_in, truncated to 17 bits.
  - Special case x_in = -2^17 gives mag = 17'h1FFFF.
  - a_mod <= mag.
  - If mag >= SAT_MAG, go to OUT with the magnitude forced to SAT_VAL. No strobes are issued.
  - Otherwise go to LAUNCH.
- LAUNCH: start_tanh=1 for exactly this cycle; counter <= TANH_LAT-1. Go to WAIT_T if TANH_LAT>1, else to INTERP.
- WAIT_T: decrement the counter; go to INTERP when it reaches 0.
- INTERP: start_interpolation=1 for exactly this cycle; counter <= RES_LAT-1. Go to WAIT_R.
- WAIT_R: in the cycle where the counter is 0, sample tanh_result and go to OUT; otherwise decrement.
- OUT: out_valid=1.
  - y_out = sign ? -{1'b0,mag16} : {1'b0,mag16}.
  - A zero magnitude always gives y_out=0 regardless of sign (no negative zero).
  - Hold y_out and out_valid stable until out_ready. On out_valid & out_ready go to IDLE.
- a_mod is held constant from acceptance until the return to IDLE; the datapath relies on this.
- in_ready is 0 in every state except IDLE. An input arriving in the same cycle as an output handshake is not accepted until the next cycle.
- Latency with out_ready held high:
  - acceptance = cycle 0; start_tanh in cycle 1; start_interpolation in cycle 1+TANH_LAT;
  - tanh_result sampled in cycle 1+TANH_LAT+RES_LAT; out_valid from cycle 2+TANH_LAT+RES_LAT.
  - Defaults: start_tanh c1, start_interpolation c3, sample c4, out_valid c5, next acceptance c6.
  - Saturation path: out_valid in cycle 1.
- Strobes never overlap, and there is never more than one pulse of each per operation.
- in_valid is ignored while in_ready=0. x_in only needs to be stable in the acceptance cycle.

Test Plan:
- Reset, then x_in=18'h00400 with defaults; the bench model returns tanh_result=16'h3A21 in the sample cycle -> a_mod=17'h00400; start_tanh c1, start_interpolation c3; y_out=17'h03A21 with out_valid at c5.
- x_in=-1024 (18'h3FC00), model returns 16'h3A21 -> a_mod=17'h00400, y_out=17'h1C5DF.
- x_in=18'h3FFFF (-1) and x_in=18'h20000 (-2^17) -> first: a_mod=1, normal path. Second: saturation path, y_out=-65535=17'h10001 in cycle 1, and both strobes stay 0.
- x_in=0, model returns 0 -> y_out=0, out_valid at c5.
- Hold out_ready=0 for 4 cycles in OUT -> y_out/out_valid stable, in_ready=0, and a second in_valid is not accepted until one cycle after the out handshake.
- Assert reset_n=0 in the cycle of start_interpolation -> next cycle all outputs at reset values. No out_valid follows. A fresh operation then completes with normal latency.
- TANH_LAT=1, RES_LAT=3 -> strobes at c1/c2, sample at c5, out_valid at c6.
